mem_stage_ctrl: RTL and testbench

- Consumer end of the EX/MEM pipeline register: takes the EX/MEM outputs and drives the data-memory request/acknowledge port.
- Stalls upstream while an access is outstanding.
- Registers the MEM/WB pipeline stage that feeds register-file write-back.
- Supports variable-latency data memory. Non-memory instructions pass through in one cycle.

---
 rtl/mem_stage_ctrl_pkg.sv | 20 ++
 rtl/mem_stage_ctrl_if.sv | 27 ++
 rtl/mem_stage_ctrl_mem_wb_reg.sv | 43 ++++
 rtl/mem_stage_ctrl.sv | 138 +++++++++++++
 tb/tb_mem_stage_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the MEM stage controller.
package mem_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RD_W_DEF   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Width needed to count 0..n-1; at least one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge port.
// Handshake: the master raises dmem_req with dmem_we/dmem_addr/dmem_wdata and
// holds all of them stable until the cycle in which the slave raises dmem_ack;
// that cycle completes the access and dmem_rdata is valid in it for reads.
// dmem_ack while dmem_req is low carries no meaning.
interface mem_stage_ctrl_if
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl_mem_wb_reg.sv
// MEM/WB pipeline register; a cycle without i_load inserts a bubble
// (write enable cleared, data and destination held).
module mem_wb_reg
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_W   = RD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [RD_W-1:0]   i_rd,
  input  logic              i_regwrite,
  output logic [DATA_W-1:0] o_data,
  output logic [RD_W-1:0]   o_rd,
  output logic              o_regwrite
);

  logic [DATA_W-1:0] r_data;
  logic [RD_W-1:0]   r_rd;
  logic              r_regwrite;

  // Capture a completed instruction, otherwise load a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data     <= '0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
    end else if (i_load) begin
      r_data     <= i_data;
      r_rd       <= i_rd;
      r_regwrite <= i_regwrite;
    end else begin
      r_regwrite <= 1'b0;
    end
  end

  assign o_data     = r_data;
  assign o_rd       = r_rd;
  assign o_regwrite = r_regwrite;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: issues data-memory accesses from EX/MEM, stalls the
// pipeline while an access is outstanding and feeds the MEM/WB register.
// Optional abort of a hung access is enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int RD_W           = RD_W_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ALUresEX,
  input  logic [DATA_W-1:0] StoreDataEX,
  input  logic [RD_W-1:0]   EX_MEMRd,
  input  logic              MemReadEX,
  input  logic              MemWriteEX,
  input  logic              MemtoRegEX,
  input  logic              RegWriteEX,
  mem_stage_ctrl_if.master  dmem,
  output logic              mem_stall,
  output logic              mem_err,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_W-1:0]   MEM_WBRd,
  output logic              RegWriteWB,
  output state_t            o_dbg_state
);

  state_t            r_state;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic [RD_W-1:0]   r_rd;
  logic              r_memtoreg;
  logic              r_regwrite;

  logic w_idle, w_memop, w_req, w_ack, w_timeout, w_load, w_memtoreg;
  logic [DATA_W-1:0] w_alu;

  assign w_idle  = (r_state == IDLE);
  assign w_memop = MemReadEX | MemWriteEX;
  // In IDLE the request follows EX/MEM directly; reset forces it low at once.
  assign w_req   = w_idle ? (rst_n & w_memop) : 1'b1;
  assign w_ack   = w_req & dmem.dmem_ack;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  assign w_timeout = !w_idle && !dmem.dmem_ack &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign mem_err   = r_err;
`else
  assign w_timeout = 1'b0;
  assign mem_err   = 1'b0;
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  assign dmem.dmem_req   = w_req;
  assign dmem.dmem_we    = w_idle ? (w_req & MemWriteEX) : r_we;
  assign dmem.dmem_addr  = w_idle ? (w_req ? ALUresEX : '0) : r_addr;
  assign dmem.dmem_wdata = w_idle ? (w_req ? StoreDataEX : '0) : r_wdata;

  // A timed-out access releases the stall so the aborted instruction leaves.
  assign mem_stall = w_req & !dmem.dmem_ack & !w_timeout;

  // MEM/WB loads on a non-memory instruction or on a completed access.
  assign w_load     = w_idle ? (!w_memop | w_ack) : w_ack;
  assign w_memtoreg = w_idle ? MemtoRegEX : r_memtoreg;
  assign w_alu      = w_idle ? ALUresEX : r_addr;

  // Request FSM: latch the access when memory does not answer immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_rd       <= '0;
      r_memtoreg <= 1'b0;
      r_regwrite <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_cnt      <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      r_err <= w_timeout;
`endif
      case (r_state)
        IDLE: begin
          if (w_memop && !dmem.dmem_ack) begin
            r_state    <= WAIT;
            r_addr     <= ALUresEX;
            r_wdata    <= StoreDataEX;
            r_we       <= MemWriteEX;
            r_rd       <= EX_MEMRd;
            r_memtoreg <= MemtoRegEX;
            r_regwrite <= RegWriteEX;
`ifdef MEM_TIMEOUT_EN
            r_cnt      <= '0;
`endif
          end
        end
        WAIT: begin
          if (dmem.dmem_ack || w_timeout) begin
            r_state <= IDLE;
          end
`ifdef MEM_TIMEOUT_EN
          else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .RD_W   (RD_W)
  ) u_mem_wb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_data     ((w_req && w_memtoreg) ? dmem.dmem_rdata : w_alu),
    .i_rd       (w_idle ? EX_MEMRd : r_rd),
    .i_regwrite (w_idle ? RegWriteEX : r_regwrite),
    .o_data     (wb_data),
    .o_rd       (MEM_WBRd),
    .o_regwrite (RegWriteWB)
  );

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: single-cycle vector table plus multi-cycle
// sequences (stalled store, back-to-back, reset mid-access, timeout).
module tb_mem_stage_ctrl;
  import mem_stage_pkg::*;

`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] alu_ex, sd_ex;
  logic [3:0]  rd_ex;
  logic        mr_ex, mw_ex, m2r_ex, rw_ex;
  logic        mem_stall, mem_err, regwrite_wb;
  logic [31:0] wb_data;
  logic [3:0]  wbrd;
  state_t      dbg_state;

  mem_stage_ctrl_if #(.DATA_W(32)) dmem_bus ();

  mem_stage_ctrl #(.DATA_W(32), .RD_W(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ALUresEX(alu_ex), .StoreDataEX(sd_ex), .EX_MEMRd(rd_ex),
    .MemReadEX(mr_ex), .MemWriteEX(mw_ex), .MemtoRegEX(m2r_ex), .RegWriteEX(rw_ex),
    .dmem(dmem_bus.master),
    .mem_stall(mem_stall), .mem_err(mem_err),
    .wb_data(wb_data), .MEM_WBRd(wbrd), .RegWriteWB(regwrite_wb),
    .o_dbg_state(dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];
  logic [31:0] m_data = '0;
  logic [3:0]  m_rd   = '0;
  logic        m_rw   = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_bus(input string nm, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic stall, input logic err);
    check({nm, " dmem_req"},   dmem_bus.dmem_req,   req);
    check({nm, " dmem_we"},    dmem_bus.dmem_we,    we);
    check({nm, " dmem_addr"},  dmem_bus.dmem_addr,  addr);
    check({nm, " dmem_wdata"}, dmem_bus.dmem_wdata, wd);
    check({nm, " mem_stall"},  mem_stall,           stall);
    check({nm, " mem_err"},    mem_err,             err);
  endtask

  // Model the MEM/WB register for one edge, then compare after that edge.
  task automatic tick(input string nm, input logic load, input logic [31:0] d,
                      input logic [3:0] rd, input logic rw);
    logic [36:0] e;
    if (load) begin
      m_data = d; m_rd = rd; m_rw = rw;
    end else begin
      m_rw = 1'b0;
    end
    exp_q.push_back({m_data, m_rd, m_rw});
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin
      check({nm, " scoreboard empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check({nm, " mem_wb"}, {wb_data, wbrd, regwrite_wb}, e);
    end
  endtask

  // ---------------- driver ----------------
  task automatic set_in(input logic [31:0] alu, input logic [31:0] sd, input logic [3:0] rd,
                        input logic mr, input logic mw, input logic m2r, input logic rw,
                        input logic ack, input logic [31:0] rdata);
    alu_ex = alu; sd_ex = sd; rd_ex = rd;
    mr_ex = mr; mw_ex = mw; m2r_ex = m2r; rw_ex = rw;
    dmem_bus.dmem_ack = ack; dmem_bus.dmem_rdata = rdata;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [31:0] alu; logic [31:0] sd; logic [3:0] rd;
    logic mr; logic mw; logic m2r; logic rw; logic ack; logic [31:0] rdata;
    logic e_req; logic e_we; logic [31:0] e_addr; logic [31:0] e_wd;
    logic [31:0] e_wb; logic [3:0] e_rd; logic e_rw;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{alu:32'h1234, sd:32'h0, rd:4'd5, mr:0, mw:0, m2r:0, rw:1, ack:0, rdata:32'h0,
              e_req:0, e_we:0, e_addr:32'h0, e_wd:32'h0, e_wb:32'h1234, e_rd:4'd5, e_rw:1};
    vt[1] = '{alu:32'h40, sd:32'h0, rd:4'd3, mr:1, mw:0, m2r:1, rw:1, ack:1, rdata:32'hDEADBEEF,
              e_req:1, e_we:0, e_addr:32'h40, e_wd:32'h0, e_wb:32'hDEADBEEF, e_rd:4'd3, e_rw:1};
    vt[2] = '{alu:32'h100, sd:32'hA5A5, rd:4'd2, mr:0, mw:1, m2r:0, rw:0, ack:1, rdata:32'h1111,
              e_req:1, e_we:1, e_addr:32'h100, e_wd:32'hA5A5, e_wb:32'h100, e_rd:4'd2, e_rw:0};
    vt[3] = '{alu:32'h44, sd:32'h77, rd:4'd1, mr:1, mw:1, m2r:0, rw:0, ack:1, rdata:32'h2222,
              e_req:1, e_we:1, e_addr:32'h44, e_wd:32'h77, e_wb:32'h44, e_rd:4'd1, e_rw:0};
    vt[4] = '{alu:32'h9, sd:32'h3, rd:4'd9, mr:0, mw:0, m2r:1, rw:1, ack:1, rdata:32'hFFFF,
              e_req:0, e_we:0, e_addr:32'h0, e_wd:32'h0, e_wb:32'h9, e_rd:4'd9, e_rw:1};
    vt[5] = '{alu:32'hCAFE, sd:32'h0, rd:4'hF, mr:0, mw:0, m2r:0, rw:0, ack:0, rdata:32'h0,
              e_req:0, e_we:0, e_addr:32'h0, e_wd:32'h0, e_wb:32'hCAFE, e_rd:4'hF, e_rw:0};

    set_in(32'h0, 32'h0, 4'd0, 0, 0, 0, 0, 0, 32'h0);

    // Reset state
    #3;
    chk_bus("reset", 0, 0, 32'h0, 32'h0, 0, 0);
    check("reset wb_data", wb_data, 32'h0);
    check("reset MEM_WBRd", wbrd, 4'd0);
    check("reset RegWriteWB", regwrite_wb, 1'b0);
    check("reset state", dbg_state, IDLE);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-cycle vectors
    for (int i = 0; i < 6; i++) begin
      set_in(vt[i].alu, vt[i].sd, vt[i].rd, vt[i].mr, vt[i].mw, vt[i].m2r, vt[i].rw,
             vt[i].ack, vt[i].rdata);
      #3;
      chk_bus($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_we, vt[i].e_addr, vt[i].e_wd, 0, 0);
      check($sformatf("vec%0d state", i), dbg_state, IDLE);
      tick($sformatf("vec%0d", i), 1'b1, vt[i].e_wb, vt[i].e_rd, vt[i].e_rw);
    end

    // Random ALU pass-through ops
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      logic [3:0]  r;
      logic        w;
      a = $urandom; r = 4'($urandom_range(0, 15)); w = 1'($urandom_range(0, 1));
      set_in(a, $urandom, r, 0, 0, 1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)), $urandom);
      #3;
      check($sformatf("rnd%0d stall", i), mem_stall, 1'b0);
      tick($sformatf("rnd%0d", i), 1'b1, a, r, w);
    end

    // 3-cycle store; inputs change while waiting and must be ignored
    set_in(32'h80, 32'h55, 4'd6, 0, 1, 0, 0, 0, 32'h0);
    #3; chk_bus("st c1", 1, 1, 32'h80, 32'h55, 1, 0);
    tick("st c1", 0, 0, 0, 0);
    set_in(32'hBAD0, 32'hBAD1, 4'd12, 1, 0, 1, 1, 0, 32'h0);
    #3; chk_bus("st c2", 1, 1, 32'h80, 32'h55, 1, 0);
    check("st c2 state", dbg_state, WAIT);
    tick("st c2", 0, 0, 0, 0);
    set_in(32'hBAD2, 32'hBAD3, 4'd13, 0, 0, 0, 1, 1, 32'h9999);
    #3; chk_bus("st c3", 1, 1, 32'h80, 32'h55, 0, 0);
    tick("st c3", 1, 32'h80, 4'd6, 0);
    set_in(32'h0, 32'h0, 4'd0, 0, 0, 0, 0, 0, 32'h0);
    #3; check("st after state", dbg_state, IDLE);
    tick("st after", 1, 32'h0, 4'd0, 0);

    // Back-to-back: 2-cycle load then ALU op
    set_in(32'h200, 32'h0, 4'd4, 1, 0, 1, 1, 0, 32'h0);
    #3; chk_bus("b2b c1", 1, 0, 32'h200, 32'h0, 1, 0);
    tick("b2b c1", 0, 0, 0, 0);
    set_in(32'h777, 32'h0, 4'd7, 0, 0, 0, 1, 1, 32'h12345678);
    #3; chk_bus("b2b c2", 1, 0, 32'h200, 32'h0, 0, 0);
    tick("b2b c2", 1, 32'h12345678, 4'd4, 1);
    dmem_bus.dmem_ack = 1'b0;
    #3; chk_bus("b2b c3", 0, 0, 32'h0, 32'h0, 0, 0);
    tick("b2b c3", 1, 32'h777, 4'd7, 1);

    // Reset in the middle of WAIT
    set_in(32'h300, 32'h0, 4'd8, 1, 0, 1, 1, 0, 32'h0);
    #3; tick("rst c1", 0, 0, 0, 0);
    #3; check("rst wait req", dmem_bus.dmem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_bus("rst mid", 0, 0, 32'h0, 32'h0, 0, 0);
    check("rst mid wb_data", wb_data, 32'h0);
    check("rst mid RegWriteWB", regwrite_wb, 1'b0);
    m_data = '0; m_rd = '0; m_rw = 1'b0;
    @(posedge clk); #1;
    set_in(32'h42, 32'h0, 4'd8, 0, 0, 0, 1, 1, 32'hAAAA);
    rst_n = 1'b1;
    #3;
    check("rst after state", dbg_state, IDLE);
    check("rst after RegWriteWB", regwrite_wb, 1'b0);
    chk_bus("rst after", 0, 0, 32'h0, 32'h0, 0, 0);
    tick("rst after", 1, 32'h42, 4'd8, 1);

`ifdef MEM_TIMEOUT_EN
    // Timeout with no ack: 4 WAIT cycles, then abort
    set_in(32'h500, 32'h0, 4'd10, 1, 0, 1, 1, 0, 32'h0);
    #3; chk_bus("to c0", 1, 0, 32'h500, 32'h0, 1, 0);
    tick("to c0", 0, 0, 0, 0);
    for (int i = 0; i < TO; i++) begin
      #3; chk_bus($sformatf("to w%0d", i), 1, 0, 32'h500, 32'h0, (i < TO - 1), 0);
      tick($sformatf("to w%0d", i), 0, 0, 0, 0);
    end
    set_in(32'h0, 32'h0, 4'd0, 0, 0, 0, 0, 0, 32'h0);
    #3; chk_bus("to abort", 0, 0, 32'h0, 32'h0, 0, 1);
    check("to abort state", dbg_state, IDLE);
    tick("to abort", 1, 32'h0, 4'd0, 0);
    #3; check("to err pulse end", mem_err, 1'b0);
    tick("to idle", 1, 32'h0, 4'd0, 0);

    // Ack on the terminal cycle wins
    set_in(32'h600, 32'h0, 4'd11, 1, 0, 1, 1, 0, 32'h0);
    #3; tick("toa c0", 0, 0, 0, 0);
    for (int i = 0; i < TO; i++) begin
      dmem_bus.dmem_ack = (i == TO - 1);
      dmem_bus.dmem_rdata = 32'hBEEF;
      #3; chk_bus($sformatf("toa w%0d", i), 1, 0, 32'h600, 32'h0, (i < TO - 1), 0);
      tick($sformatf("toa w%0d", i), (i == TO - 1), 32'hBEEF, 4'd11, 1);
    end
    set_in(32'h0, 32'h0, 4'd0, 0, 0, 0, 0, 0, 32'h0);
    #3; check("toa after err", mem_err, 1'b0);
    check("toa after state", dbg_state, IDLE);
    tick("toa after", 1, 32'h0, 4'd0, 0);
`endif

    check("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
